lsu_mem_if: RTL
===============

// Module: lsu_mem_if
// PURPOSE
// Data-memory access unit for the 3-stage core. Takes load/store requests from stage 3, drives the external
// word-wide memory bus over a req/ack handshake, and returns aligned, extended load data to writeback.
// Produces mem_busy for pipeline_ctrl: stores are posted, loads block until data returns.
// PARAMETERS
// ADDR_W       32   byte-address width; bus_addr is word aligned (bits [1:0] forced to 0)
// BUS_TIMEOUT  255  max cycles bus_req is held without bus_ack before the access is aborted (1..65535)
// PORTS
// clk          in   1       clock, rising edge
// rst          in   1       asynchronous, active-low reset
// ld_req       in   1       load request from stage 3 (level; sampled only when mem_busy=0)
// st_req       in   1       store request from stage 3 (level; sampled only when mem_busy=0)
// func3        in   3       RV32I width: 000 B, 001 H, 010 W, 100 BU, 101 HU (loads); 000/001/010 (stores)
// addr         in   ADDR_W  byte address of the access
// wdata        in   32      store data (low bytes significant for SB/SH)
// ld_rd        in   5       destination register of the load
// ld_valid     out  1       1-cycle pulse: ld_data/ld_rd_out are valid
// ld_data      out  32      extended load result
// ld_rd_out    out  5       destination register tag returned with ld_data
// mem_busy     out  1       access in flight (state != IDLE)
// acc_err      out  1       1-cycle pulse: misaligned address or illegal func3; no bus access made
// timeout_err  out  1       1-cycle pulse: access aborted after BUS_TIMEOUT cycles without ack
// bus_req      out  1       bus request; held until bus_ack
// bus_we       out  1       1 = write, 0 = read
// bus_addr     out  ADDR_W  word-aligned address
// bus_wdata    out  32      lane-replicated write data
// bus_be       out  4       byte enables (bit i = byte lane i)
// bus_ack      in   1       bus completion, 1 cycle; ignored when bus_req=0
// bus_rdata    in   32      read data, valid with bus_ack
// BEHAVIOUR
// - Reset: all outputs 0; state IDLE; timeout counter 0. Reset mid-access aborts immediately: bus_req=0,
//   no ld_valid, no error pulse.
// - FSM: IDLE, WRITE, READ. mem_busy = (state != IDLE), decoded from the state register.
// - IDLE, st_req=1 (takes priority over ld_req; the load is dropped): capture addr/wdata/func3.
//   Next cycle: state WRITE, bus_req=1, bus_we=1.
// - IDLE, ld_req=1 and st_req=0: capture addr/func3/ld_rd. Next cycle: state READ, bus_req=1, bus_we=0.
// - Requests seen while mem_busy=1 are ignored; the requester holds them.
// - Legality check at acceptance: H/HU with addr[0]!=0, W with addr[1:0]!=0, loads with func3 011/110/111,
//   and stores with func3 > 010 are illegal -> acc_err pulses next cycle, state stays IDLE, no bus cycle,
//   no ld_valid.
// - Byte lanes: B: be=4'b0001<<addr[1:0], wdata byte replicated x4. H: be=4'b0011<<{addr[1],1'b0},
//   halfword replicated x2. W: be=4'b1111. bus_be is 4'b0000 on reads.
// - bus_addr, bus_we, bus_be, bus_wdata are stable while bus_req=1.
// - WRITE, bus_ack=1: next cycle bus_req=0, state IDLE.
// - READ, bus_ack=1: next cycle bus_req=0, state IDLE, ld_valid=1 with ld_rd_out=captured tag and
//   ld_data = lane extract of bus_rdata: B sign-extended, BU zero-extended, H sign, HU zero, W as-is.
// - Latency: request accepted at cycle t, bus_req high t+1..t+k (ack at t+k), ld_valid at t+k+1,
//   mem_busy high t+1..t+k. Zero-wait bus: ld_valid at t+2.
// - Back-to-back: a new request is accepted in the same cycle mem_busy falls (cycle t+k+1).
// - Timeout: counter clears on acceptance and increments each cycle bus_req=1 without ack. On the BUS_TIMEOUT-th
//   such cycle: next cycle bus_req=0, timeout_err=1, state IDLE. A timed-out load returns ld_valid with data 0.
//   bus_ack in the same cycle as the limit wins; no timeout.
// - ld_data and ld_rd_out hold their last value between pulses.
// TESTING
// - LW addr=0x100, ack after 3 cycles, rdata=0x8765_4321 -> bus_req 3 cycles, be=0000, ld_valid with 0x87654321, tag kept.
// - LB addr=0x103, rdata=0x80xx_xxxx -> 0xFFFFFF80; LBU same -> 0x00000080; LHU addr=0x102 -> upper half zero-extended.
// - SB addr=0x201, wdata=0x0000_00AB -> bus_be=0010, bus_wdata=0xABABABAB, mem_busy until ack then 0.
// - LH addr=0x101 or SW addr=0x202 -> acc_err pulse, bus_req never asserted, mem_busy stays 0.
// - Bus never acks, BUS_TIMEOUT=4 -> bus_req for 4 cycles, then timeout_err pulse; the load returns 0.
// - st_req and ld_req together, then rst low during WRITE -> store issued first; rst drops bus_req at once, no ld_valid.

Source files
------------

// File: rtl/lsu_mem_if_if.sv
// Word-wide external data-memory bus: request/ack handshake with byte enables.
interface lsu_mem_if_if #(
    parameter int unsigned ADDR_W = 32
);
    localparam int unsigned DATA_W = 32;
    localparam int unsigned BE_W   = 4;

    logic              bus_req;
    logic              bus_we;
    logic [ADDR_W-1:0] bus_addr;
    logic [DATA_W-1:0] bus_wdata;
    logic [BE_W-1:0]   bus_be;
    logic              bus_ack;
    logic [DATA_W-1:0] bus_rdata;

    modport master (
        output bus_req, bus_we, bus_addr, bus_wdata, bus_be,
        input  bus_ack, bus_rdata
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_wdata, bus_be,
        output bus_ack, bus_rdata
    );
endinterface

// File: rtl/lsu_mem_if.sv
// Load/store unit memory interface: posted stores, blocking loads, lane steering,
// sign/zero extension, legality check and bus timeout.
module lsu_mem_if #(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned BUS_TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ld_req,
    input  logic              st_req,
    input  logic [2:0]        func3,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    input  logic [4:0]        ld_rd,
    output logic              ld_valid,
    output logic [31:0]       ld_data,
    output logic [4:0]        ld_rd_out,
    output logic              mem_busy,
    output logic              acc_err,
    output logic              timeout_err,
    lsu_mem_if_if.master      bus
);
    localparam int unsigned DATA_W = 32;
    localparam int unsigned BE_W   = 4;
    localparam int unsigned RD_W   = 5;
    localparam int unsigned CNT_W  = 16;

    typedef enum logic [1:0] {IDLE, WRITE, READ} state_e;

    state_e            state_q, state_d;
    logic              bus_req_q, bus_req_d;
    logic              bus_we_q, bus_we_d;
    logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
    logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;
    logic [BE_W-1:0]   bus_be_q, bus_be_d;
    logic [2:0]        func3_q, func3_d;
    logic [1:0]        lane_q, lane_d;
    logic [RD_W-1:0]   rd_q, rd_d;
    logic [CNT_W-1:0]  tmo_cnt_q, tmo_cnt_d;
    logic              ld_valid_q, ld_valid_d;
    logic [DATA_W-1:0] ld_data_q, ld_data_d;
    logic [RD_W-1:0]   ld_rd_q, ld_rd_d;
    logic              acc_err_q, acc_err_d;
    logic              tmo_err_q, tmo_err_d;

    logic              legal;
    logic [BE_W-1:0]   st_be;
    logic [DATA_W-1:0] st_wdata;
    logic [DATA_W-1:0] rd_shift;
    logic [DATA_W-1:0] ld_ext;

    // Width/alignment legality and store lane steering for the incoming request.
    always_comb begin
        legal    = 1'b0;
        st_be    = 4'b1111;
        st_wdata = wdata;
        case (func3)
            3'b000:         legal = 1'b1;
            3'b001:         legal = ~addr[0];
            3'b010:         legal = (addr[1:0] == 2'b00);
            3'b100, 3'b101: legal = ~st_req & (~func3[0] | ~addr[0]);
            default:        legal = 1'b0;
        endcase
        case (func3[1:0])
            2'b00: begin
                st_be    = 4'b0001 << addr[1:0];
                st_wdata = {4{wdata[7:0]}};
            end
            2'b01: begin
                st_be    = 4'b0011 << {addr[1], 1'b0};
                st_wdata = {2{wdata[15:0]}};
            end
            default: ;
        endcase
    end

    // Read-lane extraction and extension using the captured access width.
    always_comb begin
        rd_shift = bus.bus_rdata >> {lane_q, 3'b000};
        case (func3_q)
            3'b000:  ld_ext = {{24{rd_shift[7]}}, rd_shift[7:0]};
            3'b100:  ld_ext = {24'h0, rd_shift[7:0]};
            3'b001:  ld_ext = {{16{rd_shift[15]}}, rd_shift[15:0]};
            3'b101:  ld_ext = {16'h0, rd_shift[15:0]};
            default: ld_ext = rd_shift;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        bus_be_d    = bus_be_q;
        func3_d     = func3_q;
        lane_d      = lane_q;
        rd_d        = rd_q;
        tmo_cnt_d   = tmo_cnt_q;
        ld_valid_d  = 1'b0;
        ld_data_d   = ld_data_q;
        ld_rd_d     = ld_rd_q;
        acc_err_d   = 1'b0;
        tmo_err_d   = 1'b0;

        case (state_q)
            IDLE: begin
                bus_req_d = 1'b0;
                if (st_req || ld_req) begin
                    if (!legal) begin
                        acc_err_d = 1'b1;
                    end else begin
                        // Store wins when both are requested; the load is dropped.
                        state_d    = st_req ? WRITE : READ;
                        bus_req_d  = 1'b1;
                        bus_we_d   = st_req;
                        bus_addr_d = {addr[ADDR_W-1:2], 2'b00};
                        bus_be_d   = st_req ? st_be : 4'b0000;
                        if (st_req) bus_wdata_d = st_wdata;
                        func3_d    = func3;
                        lane_d     = addr[1:0];
                        rd_d       = ld_rd;
                        tmo_cnt_d  = '0;
                    end
                end
            end
            WRITE, READ: begin
                if (bus.bus_ack) begin
                    state_d   = IDLE;
                    bus_req_d = 1'b0;
                    if (state_q == READ) begin
                        ld_valid_d = 1'b1;
                        ld_data_d  = ld_ext;
                        ld_rd_d    = rd_q;
                    end
                end else if (tmo_cnt_q == CNT_W'(BUS_TIMEOUT - 1)) begin
                    state_d   = IDLE;
                    bus_req_d = 1'b0;
                    tmo_err_d = 1'b1;
                    if (state_q == READ) begin
                        ld_valid_d = 1'b1;
                        ld_data_d  = '0;
                        ld_rd_d    = rd_q;
                    end
                end else begin
                    tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d   = IDLE;
                bus_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            bus_be_q    <= '0;
            func3_q     <= '0;
            lane_q      <= '0;
            rd_q        <= '0;
            tmo_cnt_q   <= '0;
            ld_valid_q  <= 1'b0;
            ld_data_q   <= '0;
            ld_rd_q     <= '0;
            acc_err_q   <= 1'b0;
            tmo_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            bus_be_q    <= bus_be_d;
            func3_q     <= func3_d;
            lane_q      <= lane_d;
            rd_q        <= rd_d;
            tmo_cnt_q   <= tmo_cnt_d;
            ld_valid_q  <= ld_valid_d;
            ld_data_q   <= ld_data_d;
            ld_rd_q     <= ld_rd_d;
            acc_err_q   <= acc_err_d;
            tmo_err_q   <= tmo_err_d;
        end
    end

    assign mem_busy      = (state_q != IDLE);
    assign ld_valid      = ld_valid_q;
    assign ld_data       = ld_data_q;
    assign ld_rd_out     = ld_rd_q;
    assign acc_err       = acc_err_q;
    assign timeout_err   = tmo_err_q;
    assign bus.bus_req   = bus_req_q;
    assign bus.bus_we    = bus_we_q;
    assign bus.bus_addr  = bus_addr_q;
    assign bus.bus_wdata = bus_wdata_q;
    assign bus.bus_be    = bus_be_q;
endmodule
